// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Default cycle constants target the 50 MHz board reference clock.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        PLLRST    = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_sup_state_t;

    localparam int unsigned DEF_SYNC_STAGES         = 2;
    localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;  // 1 ms at 50 MHz
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_CNT_W               = 8;

    // Increment that holds at 2^width-1 instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit synchronizer: STAGES-deep flop chain with synchronous
// active-high reset. Output is the last flop of the chain.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Holds the PLL in reset, waits for lock with timeout/retry, qualifies lock
// as stable before releasing sys_rst, and counts lock losses and retries.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned CNT_W               = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             relock,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             pll_ready,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] retry_count,
    output pll_sup_state_t   fsm_state
);

    localparam int unsigned MAX_AB   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                       PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_CYC  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_BITS = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [CNT_BITS-1:0] RST_LAST     = CNT_BITS'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] TIMEOUT_LAST = CNT_BITS'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] STABLE_LAST  = CNT_BITS'(LOCK_STABLE_CYCLES - 1);

    logic                lk;
    pll_sup_state_t      state;
    pll_sup_state_t      state_next;
    logic [CNT_BITS-1:0] cnt;
    logic                cnt_clr;
    logic                loss_inc;
    logic                retry_inc;

    bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk(refclk),
        .rst(rst),
        .d  (locked),
        .q  (lk)
    );

    // relock outranks every state-local transition, including a RUN loss.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        loss_inc   = 1'b0;
        retry_inc  = 1'b0;
        if (relock) begin
            state_next = PLLRST;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                PLLRST: begin
                    if (cnt == RST_LAST) state_next = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state_next = STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_next = PLLRST;
                        retry_inc  = 1'b1;
                    end
                end
                STABLE: begin
                    if (!lk) state_next = WAIT_LOCK;
                    else if (cnt == STABLE_LAST) state_next = RUN;
                end
                RUN: begin
                    if (!lk) begin
                        state_next = WAIT_LOCK;
                        loss_inc   = 1'b1;
                    end
                end
                default: state_next = PLLRST;
            endcase
        end
        if (state_next != state) cnt_clr = 1'b1;
    end

    // Outputs are registered from state_next so they move with the state flop.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= PLLRST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            pll_ready   <= 1'b0;
            loss_count  <= '0;
            retry_count <= '0;
        end else begin
            state <= state_next;
            // RUN has no terminal count, so the counter parks at zero there.
            if (cnt_clr || state == RUN) cnt <= '0;
            else cnt <= cnt + CNT_BITS'(1);
            pll_rst   <= (state_next == PLLRST);
            sys_rst   <= (state_next != RUN);
            pll_ready <= (state_next == RUN);
            if (loss_inc) loss_count <= CNT_W'(sat_inc(32'(loss_count), CNT_W));
            if (retry_inc) retry_count <= CNT_W'(sat_inc(32'(retry_count), CNT_W));
        end
    end

    assign fsm_state = state;

endmodule
